// File: rtl/uart_hex_word_formatter.sv
// uart_hex_word_formatter
// Buffers 32-bit words in a small FIFO and streams each one out as lowercase
// ASCII hex digits (most significant used nibble first) followed by a
// terminator (CR LF or a single space), one byte per valid/ready transfer.
// Intended to feed a byte-wide UART transmit emitter directly.

module uart_hex_word_formatter #(
    parameter int DEPTH   = 4,  // word FIFO depth, power of 2, >= 2
    parameter int NIBBLES = 8,  // hex digits per word, 1..8
    parameter int CRLF    = 1   // 1: terminator 0x0D 0x0A, 0: terminator 0x20
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [31:0]                i_word,
    input  logic                       i_word_valid,
    output logic                       o_word_ready,
    output logic [7:0]                 o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_busy,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int TOP = 4 * NIBBLES - 1;   // bit index of the digit presented next

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIGITS,
        S_TERM,
        S_TERM2
    } state_e;

    // Lowercase ASCII hex encoding of one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;

    state_e        state_q, state_d;
    logic [31:0]   sh_q, sh_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;

    logic          full, empty, push, pop, xfer;
    logic [31:0]   head;

    assign full         = (level_q == LW'(DEPTH));
    assign empty        = (level_q == '0);
    assign o_word_ready = !full && !i_rst;
    assign push         = i_word_valid && o_word_ready;
    assign pop          = (state_q == S_IDLE) && !empty;
    assign xfer         = valid_q && i_ready;
    assign head         = mem[rd_ptr_q];

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_busy  = !empty || (state_q != S_IDLE);
    assign o_level = level_q;

    // FIFO storage: written on every accepted word.
    // NOTE: storage is not reset; level_q alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_word;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves level unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // State register plus the registered byte-stream datapath.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic: advance only on a completed byte transfer.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (!empty)               state_d = S_DIGITS;
            S_DIGITS: if (xfer && cnt_q == '0)  state_d = S_TERM;
            S_TERM:   if (xfer)                 state_d = (CRLF != 0) ? S_TERM2 : S_IDLE;
            S_TERM2:  if (xfer)                 state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic: pick the byte presented after each transfer.
    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    // Present the first digit now and keep the rest pre-shifted.
                    sh_d    = head << 4;
                    cnt_d   = 3'(NIBBLES - 1);
                    valid_d = 1'b1;
                    data_d  = hex_ascii(head[TOP -: 4]);
                end else begin
                    valid_d = 1'b0;
                end
            end
            S_DIGITS: begin
                if (xfer) begin
                    if (cnt_q == '0) begin
                        data_d = (CRLF != 0) ? 8'h0D : 8'h20;
                    end else begin
                        data_d = hex_ascii(sh_q[TOP -: 4]);
                        sh_d   = sh_q << 4;
                        cnt_d  = cnt_q - 3'd1;
                    end
                end
            end
            S_TERM: begin
                if (xfer) begin
                    if (CRLF != 0) data_d  = 8'h0A;
                    else           valid_d = 1'b0;
                end
            end
            S_TERM2: begin
                if (xfer) valid_d = 1'b0;
            end
            default: valid_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_hex_word_formatter.sv
// Self-checking bench for uart_hex_word_formatter: a default instance
// (DEPTH=4, NIBBLES=8, CRLF=1) and a NIBBLES=2, CRLF=0 instance.

module tb_uart_hex_word_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] a_word   = '0;
    logic        a_wvalid = 1'b0;
    logic        a_wready;
    logic [7:0]  a_data;
    logic        a_valid;
    logic        a_ready  = 1'b0;
    logic        a_busy;
    logic [2:0]  a_level;

    logic [31:0] b_word   = '0;
    logic        b_wvalid = 1'b0;
    logic        b_wready;
    logic [7:0]  b_data;
    logic        b_valid;
    logic        b_ready  = 1'b1;
    logic        b_busy;
    logic [2:0]  b_level;

    uart_hex_word_formatter #(.DEPTH(4), .NIBBLES(8), .CRLF(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_word(a_word), .i_word_valid(a_wvalid),
        .o_word_ready(a_wready), .o_data(a_data), .o_valid(a_valid),
        .i_ready(a_ready), .o_busy(a_busy), .o_level(a_level)
    );

    uart_hex_word_formatter #(.DEPTH(4), .NIBBLES(2), .CRLF(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_word(b_word), .i_word_valid(b_wvalid),
        .o_word_ready(b_wready), .o_data(b_data), .o_valid(b_valid),
        .i_ready(b_ready), .o_busy(b_busy), .o_level(b_level)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  qa[$];
    int unsigned sa[$];
    logic [7:0]  qb[$];
    int          ready_mode = 1;   // 0: stalled, 1: always ready, 2: ready 1 cycle in 4
    logic        a_prev_stall = 1'b0;
    logic [7:0]  a_prev_data  = '0;

    typedef struct {
        logic [31:0] word;
        logic [63:0] hex;     // expected digit characters, first char in the MSBs
        int          rmode;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] cap_word[6];
    logic [63:0] cap_hex[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_ready();
        case (ready_mode)
            0:       a_ready = 1'b0;
            1:       a_ready = 1'b1;
            default: a_ready = (cyc % 4 == 0);
        endcase
    endtask

    task automatic set_ready(input int m);
        ready_mode = m;
        apply_ready();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        apply_ready();
    endtask

    task automatic push_word(input logic [31:0] w);
        a_word   = w;
        a_wvalid = 1'b1;
        check("push_ready", a_wready, 1);
        tick();
        a_wvalid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (qa.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("bytes_collected", qa.size(), n);
    endtask

    function automatic logic [7:0] exp_byte(input logic [63:0] hex, input int i);
        if (i < 8)  return hex[63 - 8*i -: 8];
        if (i == 8) return 8'h0D;
        return 8'h0A;
    endfunction

    // Capture every transfer and check that stalled bytes hold stable.
    always @(negedge clk) begin
        if (a_prev_stall && !rst) begin
            check("stall_valid", a_valid, 1);
            check("stall_data", a_data, a_prev_data);
        end
        a_prev_stall = a_valid && !a_ready && !rst;
        a_prev_data  = a_data;
        if (a_valid && a_ready) begin
            qa.push_back(a_data);
            sa.push_back(cyc);
        end
        if (b_valid && b_ready) qb.push_back(b_data);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h1234ABCD, "1234abcd", 1};
        vecs[1] = '{32'h1234ABCD, "1234abcd", 2};
        vecs[2] = '{32'h89ABCDEF, "89abcdef", 1};
        vecs[3] = '{32'h0F1E2D3C, "0f1e2d3c", 2};
        vecs[4] = '{32'h00000000, "00000000", 1};
        vecs[5] = '{32'hFFFFFFFF, "ffffffff", 2};
        vecs[6] = '{32'hA5A50909, "a5a50909", 1};
        cap_word = '{32'h11111111, 32'h22222222, 32'h33333333,
                     32'h44444444, 32'h55555555, 32'h66666666};
        cap_hex  = '{"11111111", "22222222", "33333333",
                     "44444444", "55555555", "66666666"};

        // Reset state
        set_ready(1);
        repeat (3) tick();
        check("rst_valid", a_valid, 0);
        check("rst_data", a_data, 8'h00);
        check("rst_busy", a_busy, 0);
        check("rst_level", a_level, 0);
        check("rst_word_ready", a_wready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_word_ready", a_wready, 1);
        tick();

        // Latency: push at cycle N, o_valid high at N+2
        qa.delete(); sa.delete();
        a_word = 32'h1234ABCD; a_wvalid = 1'b1;
        tick();
        a_wvalid = 1'b0;
        check("lat_n1_valid", a_valid, 0);
        check("lat_n1_level", a_level, 1);
        tick();
        check("lat_n2_valid", a_valid, 1);
        check("lat_n2_data", a_data, 8'h31);
        wait_bytes(10, 50);
        for (int i = 0; i < 10; i++) check("lat_byte", qa[i], exp_byte("1234abcd", i));
        check("lat_busy_done", a_busy, 0);

        // Table-driven single words under different ready patterns
        for (int v = 0; v < 7; v++) begin
            tick();
            qa.delete(); sa.delete();
            set_ready(vecs[v].rmode);
            push_word(vecs[v].word);
            wait_bytes(10, 200);
            for (int i = 0; i < 10; i++) check("vec_byte", qa[i], exp_byte(vecs[v].hex, i));
            check("vec_busy_done", a_busy, 0);
        end

        // Back-to-back words: one idle cycle between them
        set_ready(1);
        repeat (2) tick();
        qa.delete(); sa.delete();
        push_word(32'h00000000);
        push_word(32'hFFFFFFFF);
        wait_bytes(20, 60);
        for (int i = 0; i < 10; i++) check("b2b_w0", qa[i], exp_byte("00000000", i));
        for (int i = 0; i < 10; i++) check("b2b_w1", qa[10 + i], exp_byte("ffffffff", i));
        check("b2b_word_span", sa[9] - sa[0], 9);
        check("b2b_gap", sa[10] - sa[9], 2);

        // Capacity: DEPTH in FIFO plus one in the shift register
        tick();
        qa.delete(); sa.delete();
        set_ready(0);
        for (int k = 0; k < 5; k++) push_word(cap_word[k]);
        check("cap_level", a_level, 4);
        check("cap_full_ready", a_wready, 0);
        check("cap_busy", a_busy, 1);
        a_word = cap_word[5]; a_wvalid = 1'b1;
        repeat (5) tick();
        check("cap_still_full", a_wready, 0);
        set_ready(1);
        begin
            int k = 0;
            while (!a_wready && k < 100) begin
                tick();
                k++;
            end
        end
        check("cap_ready_returns", a_wready, 1);
        check("cap_ready_after_term", qa.size() >= 10, 1);
        tick();
        a_wvalid = 1'b0;
        wait_bytes(60, 400);
        for (int w = 0; w < 6; w++)
            for (int i = 0; i < 10; i++)
                check("cap_byte", qa[w*10 + i], exp_byte(cap_hex[w], i));

        // Reset mid-word with two words queued
        repeat (2) tick();
        qa.delete(); sa.delete();
        set_ready(0);
        push_word(32'hDEADBEEF);
        push_word(32'h11111111);
        push_word(32'h22222222);
        check("mid_level", a_level, 2);
        set_ready(1);
        wait_bytes(3, 50);
        set_ready(0);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", a_valid, 0);
        check("mid_rst_level", a_level, 0);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_word_ready", a_wready, 0);
        rst = 1'b0;
        #1;
        check("mid_rel_word_ready", a_wready, 1);
        set_ready(1);
        repeat (40) tick();
        check("mid_no_more_bytes", qa.size(), 3);
        check("mid_idle_valid", a_valid, 0);
        check("mid_b0", qa[0], 8'h64);
        check("mid_b1", qa[1], 8'h65);
        check("mid_b2", qa[2], 8'h61);

        // NIBBLES=2, CRLF=0 instance
        qb.delete();
        b_word = 32'hFFFF00F0; b_wvalid = 1'b1;
        tick();
        b_wvalid = 1'b0;
        repeat (8) tick();
        check("n2_count", qb.size(), 3);
        check("n2_b0", qb[0], 8'h66);
        check("n2_b1", qb[1], 8'h30);
        check("n2_b2", qb[2], 8'h20);
        check("n2_busy", b_busy, 0);
        qb.delete();
        b_word = 32'h12345678; b_wvalid = 1'b1;
        tick();
        b_wvalid = 1'b0;
        repeat (8) tick();
        check("n2b_count", qb.size(), 3);
        check("n2b_b0", qb[0], 8'h37);
        check("n2b_b1", qb[1], 8'h38);
        check("n2b_b2", qb[2], 8'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_hex_word_formatter.md
Name: uart_hex_word_formatter

Overview:
- Upstream feeder for the byte-wide UART transmit emitter.
- Buffers 32-bit words in a small FIFO and converts each one to ASCII hex characters, MSB nibble first, followed by a terminator.
- Presents the characters one byte at a time on a valid/ready interface that connects directly to the emitter's data/valid/ready inputs.
- Used to stream core IDs, status words and debug words out over the UART.

Parameters:
- DEPTH, 4: word FIFO depth; power of 2, ≥2.
- NIBBLES, 8: hex digits emitted per word, 1..8; the low NIBBLES nibbles of the word are used.
- CRLF, 1: 1 = terminator is 0x0D then 0x0A; 0 = terminator is single 0x20.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_word  in  32  word to format.
- i_word_valid  in  1  i_word is valid.
- o_word_ready  out  1  FIFO can accept a word; combinational: !full & !i_rst.
- o_data  out  8  ASCII byte to the emitter.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  emitter ready (emitter's o_ready).
- o_busy  out  1  FIFO non-empty or a word is being emitted.
- o_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high; i_clk and i_rst only):
  - Clears FIFO pointers and level, state := IDLE, o_valid := 0, o_data := 0x00, o_busy := 0.
  - o_word_ready is 0 while i_rst is high. Writes in that cycle are ignored.
- Word push: occurs when i_word_valid & o_word_ready. Full means level == DEPTH; no write-through when full, even on a simultaneous pop.
- Byte transfer: occurs when o_valid & i_ready.
  - While o_valid is high and i_ready is low, o_data and o_valid hold stable.
  - o_valid never drops without a transfer, except on reset.
- State machine:
  - IDLE: if FIFO non-empty, pop head into a 32-bit shift register, load digit counter := NIBBLES-1, drive o_valid := 1 with o_data := ASCII(first digit), go to DIGITS. Otherwise o_valid := 0.
  - DIGITS: on each transfer, shift the word left 4 and present the next digit. On the transfer of the last digit, present the first terminator byte and go to TERM.
  - TERM (CRLF=1): on transfer of 0x0D, present 0x0A and go to TERM2. On transfer of 0x0A, o_valid := 0 and go to IDLE.
  - TERM (CRLF=0): on transfer of 0x20, o_valid := 0 and go to IDLE.
- Digit encoding:
  - 0..9 → 0x30..0x39.
  - 10..15 → 0x61..0x66 (lowercase).
  - First digit is nibble NIBBLES-1; higher nibbles are ignored.
- Latency:
  - Word accepted at cycle N into an empty FIFO with state IDLE → o_valid high at cycle N+2.
  - Between words, o_valid is low for exactly one cycle (the IDLE cycle).
- Capacity: DEPTH words in the FIFO plus 1 in the shift register.
- Simultaneous push and pop: level unchanged; both complete.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH.
- o_busy := (level != 0) | (state != IDLE).
- Reset mid-word: the sequence is discarded and o_valid is 0 the next cycle. Any byte already accepted by the emitter completes on the line; no further bytes are issued.

Test Plan:
- Push 0x1234ABCD at cycle N, i_ready tied 1 → bytes 31 32 33 34 61 62 63 64 0D 0A; o_valid first high at N+2; o_busy low after the last transfer.
- Same word with i_ready toggling 1-of-4 cycles → identical byte sequence; o_data stable across every stalled cycle; no byte duplicated or skipped.
- DEPTH=4, i_ready=0, push 6 words back-to-back:
  - Words 1–5 accepted; o_level reaches 4.
  - o_word_ready low for word 6 until word 1's terminator transfers.
  - Output order is words 1..6.
- NIBBLES=2, CRLF=0, word 0xFFFF00F0 → bytes 66 30 20 only.
- Word 0x00000000 followed by 0xFFFFFFFF, i_ready=1 → eight 0x30 + 0D 0A, one idle cycle, then eight 0x66 + 0D 0A.
- Assert i_rst for one cycle after 3 digit transfers with 2 words queued → next cycle o_valid=0, o_level=0, o_busy=0; o_word_ready=1 after reset releases; no further bytes.
